// File: rtl/cim_pkg.sv
// Shared constants and helpers for the CIM weight bank: default geometry,
// wb bit-offset mapping and one-hot legality test.
package cim_pkg;

  localparam int unsigned NBANK_D = 2;
  localparam int unsigned NBLK_D  = 9;
  localparam int unsigned WPB_D   = 16;
  localparam int unsigned WW_D    = 12;
  localparam int unsigned SW_D    = 4;

  // LSB of the wb slice for (bank, slice, word); banks outermost, words innermost.
  function automatic int unsigned wb_ofs(input int unsigned b, input int unsigned s,
                                         input int unsigned w, input int unsigned nslice,
                                         input int unsigned depth, input int unsigned sw);
    return ((b * nslice + s) * depth + w) * sw;
  endfunction

  // Vectors up to 32 bits wide; callers zero-extend.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/cim_wr_stage.sv
// Write front end: valid/ready handshake against the per-bank lock, block
// decode and legality check, and the single commit stage register.
module cim_wr_stage
  import cim_pkg::*;
#(
  parameter int unsigned NBANK = NBANK_D,
  parameter int unsigned NBLK  = NBLK_D,
  parameter int unsigned WPB   = WPB_D,
  parameter int unsigned WW    = WW_D,
  parameter int unsigned BW    = 1,
  parameter int unsigned IW    = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [NBLK-1:0]   wr_blk,
  input  logic [BW-1:0]     wr_bank,
  input  logic [WPB*WW-1:0] wr_data,
  input  logic [NBANK-1:0]  lock,
  output logic              cm_vld,
  output logic              cm_err,
  output logic [BW-1:0]     cm_bank,
  output logic [IW-1:0]     cm_idx,
  output logic [WPB*WW-1:0] cm_data
);

  logic          bank_ok;
  logic          legal;
  logic [IW-1:0] blk_idx;
  logic          stg_vld;
  logic          stg_legal;

  always_comb begin
    bank_ok  = 32'(wr_bank) < NBANK;
    // Out-of-range banks are always accepted so the error can be recorded.
    wr_ready = bank_ok ? ~lock[wr_bank] : 1'b1;
    legal    = bank_ok & is_onehot(32'(wr_blk));
    blk_idx  = '0;
    for (int unsigned j = 0; j < NBLK; j++) begin
      if (wr_blk[j]) blk_idx = IW'(j);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stg_vld   <= 1'b0;
      stg_legal <= 1'b0;
      cm_bank   <= '0;
      cm_idx    <= '0;
      cm_data   <= '0;
    end else begin
      stg_vld <= wr_valid & wr_ready;
      if (wr_valid & wr_ready) begin
        stg_legal <= legal;
        cm_bank   <= wr_bank;
        cm_idx    <= blk_idx;
        cm_data   <= wr_data;
      end
    end
  end

  assign cm_vld = stg_vld & stg_legal;
  assign cm_err = stg_vld & ~stg_legal;

endmodule

// File: rtl/cim_weight_bank.sv
// Multi-bank CIM weight store with registered sliced bitline outputs.
// Define CIM_WB_INV_EN for active-low (inverted) wb drive.
module cim_weight_bank
  import cim_pkg::*;
#(
  parameter  int unsigned NBANK  = NBANK_D,
  parameter  int unsigned NBLK   = NBLK_D,
  parameter  int unsigned WPB    = WPB_D,
  parameter  int unsigned WW     = WW_D,
  parameter  int unsigned SW     = SW_D,
  localparam int unsigned NSLICE = WW / SW,
  localparam int unsigned DEPTH  = NBLK * WPB,
  localparam int unsigned BW     = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [NBLK-1:0]                 wr_blk,
  input  logic [BW-1:0]                   wr_bank,
  input  logic [WPB*WW-1:0]               wr_data,
  input  logic [NBANK-1:0]                lock,
  input  logic [NBANK-1:0]                clr,
  output logic [NBANK*NBLK-1:0]           blk_vld,
  output logic [NBANK-1:0]                bank_full,
  output logic                            addr_err,
  input  logic                            err_clr,
  output logic [NBANK*NSLICE*DEPTH*SW-1:0] wb
);

  localparam int unsigned IW = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef CIM_WB_INV_EN
  localparam logic WB_INV = 1'b1;
`else
  localparam logic WB_INV = 1'b0;
`endif

  logic              cm_vld;
  logic              cm_err;
  logic [BW-1:0]     cm_bank;
  logic [IW-1:0]     cm_idx;
  logic [WPB*WW-1:0] cm_data;

  logic [WW-1:0]         mem [NBANK][DEPTH];
  logic [NBANK*NBLK-1:0] vld_nxt;
  logic [NBANK-1:0]      full_nxt;

  cim_wr_stage #(
    .NBANK (NBANK),
    .NBLK  (NBLK),
    .WPB   (WPB),
    .WW    (WW),
    .BW    (BW),
    .IW    (IW)
  ) u_stage (
    .clk      (clk),
    .rstn     (rstn),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_blk   (wr_blk),
    .wr_bank  (wr_bank),
    .wr_data  (wr_data),
    .lock     (lock),
    .cm_vld   (cm_vld),
    .cm_err   (cm_err),
    .cm_bank  (cm_bank),
    .cm_idx   (cm_idx),
    .cm_data  (cm_data)
  );

  // Clear is applied before the commit so a same-cycle commit bit survives.
  always_comb begin
    vld_nxt = blk_vld;
    for (int unsigned b = 0; b < NBANK; b++) begin
      if (clr[b]) vld_nxt[b*NBLK +: NBLK] = '0;
    end
    if (cm_vld) vld_nxt[32'(cm_bank) * NBLK + 32'(cm_idx)] = 1'b1;
    for (int unsigned b = 0; b < NBANK; b++) begin
      full_nxt[b] = &vld_nxt[b*NBLK +: NBLK];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned b = 0; b < NBANK; b++) begin
        for (int unsigned w = 0; w < DEPTH; w++) begin
          mem[b][w] <= '0;
        end
      end
      blk_vld   <= '0;
      bank_full <= '0;
      addr_err  <= 1'b0;
    end else begin
      if (cm_vld) begin
        for (int unsigned i = 0; i < WPB; i++) begin
          mem[cm_bank][AW'(32'(cm_idx) * WPB + i)] <= cm_data[i*WW +: WW];
        end
      end
      blk_vld   <= vld_nxt;
      bank_full <= full_nxt;
      if (cm_err)       addr_err <= 1'b1;
      else if (err_clr) addr_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb <= WB_INV ? '1 : '0;
    end else begin
      for (int unsigned b = 0; b < NBANK; b++) begin
        for (int unsigned s = 0; s < NSLICE; s++) begin
          for (int unsigned w = 0; w < DEPTH; w++) begin
            wb[wb_ofs(b, s, w, NSLICE, DEPTH, SW) +: SW] <= mem[b][w][s*SW +: SW] ^ {SW{WB_INV}};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cim_weight_bank.sv
// Directed self-checking bench for cim_weight_bank at default geometry.
module tb_cim_weight_bank;

`ifdef CIM_WB_INV_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif
  localparam int WBW = 2 * 3 * 144 * 4;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           wr_valid = 1'b0;
  logic           wr_ready;
  logic [8:0]     wr_blk = '0;
  logic [0:0]     wr_bank = '0;
  logic [191:0]   wr_data = '0;
  logic [1:0]     lock = '0;
  logic [1:0]     clr = '0;
  logic [17:0]    blk_vld;
  logic [1:0]     bank_full;
  logic           addr_err;
  logic           err_clr = 1'b0;
  logic [WBW-1:0] wb;

  int checks = 0;
  int errors = 0;

  cim_weight_bank dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_blk    (wr_blk),
    .wr_bank   (wr_bank),
    .wr_data   (wr_data),
    .lock      (lock),
    .clr       (clr),
    .blk_vld   (blk_vld),
    .bank_full (bank_full),
    .addr_err  (addr_err),
    .err_clr   (err_clr),
    .wb        (wb)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Raw 4-bit slice from wb, laid out bank/slice/word with 3 slices x 144 words.
  function automatic logic [3:0] raw_slice(input int b, input int s, input int w);
    return wb[((b * 3 + s) * 144 + w) * 4 +: 4];
  endfunction

  // Stored word reconstructed from the wb slices with the drive polarity removed.
  function automatic logic [11:0] word_of(input int b, input int w);
    logic [11:0] v;
    for (int s = 0; s < 3; s++) v[s*4 +: 4] = raw_slice(b, s, w) ^ {4{INV}};
    return v;
  endfunction

  task automatic drive(input logic bank, input logic [8:0] blk, input logic [11:0] base);
    wr_valid = 1'b1;
    wr_bank  = bank;
    wr_blk   = blk;
    for (int i = 0; i < 16; i++) wr_data[i*12 +: 12] = base + 12'(i);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    #1;
    checks++; if (wb !== {WBW{INV}}) begin errors++; $display("FAIL reset_wb: wb not at reset pattern"); end
    checks++; if (blk_vld !== 18'h0) begin errors++; $display("FAIL reset_blk_vld: got %h want 0", blk_vld); end
    checks++; if (bank_full !== 2'b00) begin errors++; $display("FAIL reset_bank_full: got %b want 00", bank_full); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %b want 0", addr_err); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
  endtask

  task automatic test_write;
    @(negedge clk) drive(1'b1, 9'b000000100, 12'h100);
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_idle: got %b want 1", wr_ready); end
    @(posedge clk); #1;
    checks++; if (blk_vld !== 18'h0) begin errors++; $display("FAIL write_stage_vld: got %h want 0", blk_vld); end
    @(negedge clk) wr_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (blk_vld !== 18'b000000100_000000000) begin errors++; $display("FAIL write_blk_vld: got %b want 000000100000000000", blk_vld); end
    checks++; if (word_of(1, 33) !== 12'h000) begin errors++; $display("FAIL write_wb_early: got %h want 000", word_of(1, 33)); end
    @(posedge clk); #1;
    checks++; if (raw_slice(1, 0, 33) !== (4'h1 ^ {4{INV}})) begin errors++; $display("FAIL write_slice0: got %h want %h", raw_slice(1, 0, 33), 4'h1 ^ {4{INV}}); end
    checks++; if (raw_slice(1, 1, 33) !== (4'h0 ^ {4{INV}})) begin errors++; $display("FAIL write_slice1: got %h want %h", raw_slice(1, 1, 33), 4'h0 ^ {4{INV}}); end
    checks++; if (raw_slice(1, 2, 33) !== (4'h1 ^ {4{INV}})) begin errors++; $display("FAIL write_slice2: got %h want %h", raw_slice(1, 2, 33), 4'h1 ^ {4{INV}}); end
    checks++; if (word_of(1, 47) !== 12'h10F) begin errors++; $display("FAIL write_word47: got %h want 10f", word_of(1, 47)); end
    checks++; if (word_of(0, 33) !== 12'h000) begin errors++; $display("FAIL write_other_bank: got %h want 000", word_of(0, 33)); end
  endtask

  task automatic test_back_to_back;
    logic [8:0] oh;
    for (int k = 0; k < 9; k++) begin
      oh = '0;
      oh[k] = 1'b1;
      @(negedge clk) drive(1'b0, oh, 12'h200 + 12'(k * 16));
      @(posedge clk);
    end
    #1;
    checks++; if (blk_vld[8:0] !== 9'h0FF || bank_full !== 2'b00) begin errors++; $display("FAIL b2b_before_full: got vld %h full %b want 0ff 00", blk_vld[8:0], bank_full); end
    @(negedge clk) wr_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bank_full !== 2'b01) begin errors++; $display("FAIL b2b_bank_full: got %b want 01", bank_full); end
    checks++; if (blk_vld[8:0] !== 9'h1FF) begin errors++; $display("FAIL b2b_blk_vld: got %h want 1ff", blk_vld[8:0]); end
    @(posedge clk); #1;
    checks++; if (word_of(0, 100) !== 12'h264) begin errors++; $display("FAIL b2b_word100: got %h want 264", word_of(0, 100)); end
    checks++; if (word_of(0, 143) !== 12'h28F) begin errors++; $display("FAIL b2b_word143: got %h want 28f", word_of(0, 143)); end
    @(negedge clk) clr = 2'b01;
    @(posedge clk); #1;
    checks++; if (bank_full !== 2'b00) begin errors++; $display("FAIL clr_bank_full: got %b want 00", bank_full); end
    checks++; if (blk_vld !== 18'b000000100_000000000) begin errors++; $display("FAIL clr_blk_vld: got %b want 000000100000000000", blk_vld); end
    @(negedge clk) clr = 2'b00;
  endtask

  task automatic test_lock;
    @(negedge clk);
    lock = 2'b01;
    drive(1'b0, 9'b000000001, 12'h500);
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL lock_ready: got %b want 0", wr_ready); end
    wr_bank = 1'b1;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL lock_other_bank_ready: got %b want 1", wr_ready); end
    wr_bank = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (blk_vld[8:0] !== 9'h000) begin errors++; $display("FAIL lock_blk_vld: got %h want 000", blk_vld[8:0]); end
    checks++; if (word_of(0, 0) !== 12'h200) begin errors++; $display("FAIL lock_mem: got %h want 200", word_of(0, 0)); end
    @(negedge clk) lock = 2'b00;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL unlock_ready: got %b want 1", wr_ready); end
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    lock = 2'b01;
    @(posedge clk); #1;
    checks++; if (blk_vld[8:0] !== 9'h001) begin errors++; $display("FAIL unlock_commit_vld: got %h want 001", blk_vld[8:0]); end
    @(posedge clk); #1;
    checks++; if (word_of(0, 0) !== 12'h500) begin errors++; $display("FAIL unlock_word0: got %h want 500", word_of(0, 0)); end
    checks++; if (word_of(0, 15) !== 12'h50F) begin errors++; $display("FAIL unlock_word15: got %h want 50f", word_of(0, 15)); end
    @(negedge clk) lock = 2'b00;
  endtask

  task automatic test_addr_err;
    @(negedge clk) drive(1'b1, 9'b000000011, 12'h700);
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL err_ready: got %b want 1", wr_ready); end
    @(posedge clk);
    @(negedge clk) wr_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL err_multihot: got %b want 1", addr_err); end
    checks++; if (blk_vld !== 18'b000000100_000000001) begin errors++; $display("FAIL err_blk_vld: got %b want 000000100000000001", blk_vld); end
    @(posedge clk); #1;
    checks++; if (word_of(1, 0) !== 12'h000 || word_of(1, 16) !== 12'h000) begin errors++; $display("FAIL err_mem: got %h %h want 000 000", word_of(1, 0), word_of(1, 16)); end
    checks++; if (word_of(1, 33) !== 12'h101) begin errors++; $display("FAIL err_mem33: got %h want 101", word_of(1, 33)); end
    @(negedge clk) err_clr = 1'b1;
    @(posedge clk); #1;
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL err_clr: got %b want 0", addr_err); end
    @(negedge clk);
    err_clr = 1'b0;
    drive(1'b0, 9'b000000000, 12'h700);
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    err_clr = 1'b1;
    @(posedge clk); #1;
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %b want 1", addr_err); end
    checks++; if (blk_vld !== 18'b000000100_000000001) begin errors++; $display("FAIL err_zero_blk_vld: got %b want 000000100000000001", blk_vld); end
    @(posedge clk); #1;
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL err_clr2: got %b want 0", addr_err); end
    @(negedge clk) err_clr = 1'b0;
  endtask

  task automatic test_clr_commit;
    @(negedge clk) drive(1'b1, 9'b000010000, 12'h3C0);
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    clr = 2'b10;
    @(posedge clk); #1;
    checks++; if (blk_vld[17:9] !== 9'b000010000) begin errors++; $display("FAIL clr_commit_bank1: got %b want 000010000", blk_vld[17:9]); end
    checks++; if (blk_vld[8:0] !== 9'h001) begin errors++; $display("FAIL clr_commit_bank0: got %h want 001", blk_vld[8:0]); end
    @(negedge clk) clr = 2'b00;
    @(posedge clk); #1;
    checks++; if (word_of(1, 64) !== 12'h3C0) begin errors++; $display("FAIL clr_commit_word64: got %h want 3c0", word_of(1, 64)); end
    checks++; if (word_of(1, 33) !== 12'h101) begin errors++; $display("FAIL clr_keeps_mem: got %h want 101", word_of(1, 33)); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk) drive(1'b0, 9'b100000000, 12'h0AA);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    wr_valid = 1'b0;
    #1;
    checks++; if (wb !== {WBW{INV}}) begin errors++; $display("FAIL midrst_wb: wb not at reset pattern"); end
    checks++; if (blk_vld !== 18'h0 || addr_err !== 1'b0) begin errors++; $display("FAIL midrst_state: got vld %h err %b want 0 0", blk_vld, addr_err); end
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    checks++; if (blk_vld !== 18'h0) begin errors++; $display("FAIL midrst_discard_vld: got %h want 0", blk_vld); end
    @(posedge clk); #1;
    checks++; if (word_of(0, 128) !== 12'h000) begin errors++; $display("FAIL midrst_discard_mem: got %h want 000", word_of(0, 128)); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_back_to_back;
    test_lock;
    test_addr_err;
    test_clr_commit;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
